mips_muldiv_unit: RTL
=====================

Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers for the single-cycle MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU over WIDTH cycles, one bit per cycle. Also supports MTHI/MTLO writes.
- The ALU stays combinational. The controller stalls the PC while busy=1; MFHI/MFLO read hi/lo directly.

Parameters:
- WIDTH, 32, operand width and width of HI and LO; must be >= 2.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request to begin an operation; sampled only in IDLE
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  in  WIDTH  rs operand (multiplicand or dividend)
- b  in  WIDTH  rt operand (multiplier or divisor)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, result written this cycle
- div_by_zero  out  1  pulses with done when a DIV or DIVU had b=0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (also mid-operation): state IDLE, hi=lo=0, busy=done=div_by_zero=0, any operation aborted without result.
- States:
  - IDLE: start=1 latches op, operand magnitudes and sign flags, clears the iteration counter, and goes to CALC. busy=1 from the next cycle.
  - CALC: one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, counter +1. Leaves after exactly WIDTH steps.
  - FIX: applies sign correction, writes hi/lo, pulses done (and div_by_zero if applicable), busy=0, returns to IDLE.
- Latency: start sampled at edge N gives done=1 and new hi/lo visible after edge N+WIDTH+1. Another start is accepted at edge N+WIDTH+2.
- Back-to-back: start held high issues a new operation every WIDTH+2 cycles.
- hi/lo hold their previous values throughout CALC. Working registers are separate from HI/LO, so an early MFHI/MFLO reads stale but stable values.
- start while busy is ignored, not queued.
- Multiply: {hi,lo} = full 2*WIDTH-bit product.
  - MULTU treats a and b as unsigned.
  - MULT treats them as two's complement; the product is negated when the operand signs differ.
- Divide: lo = quotient, hi = remainder.
  - DIVU is unsigned.
  - DIV truncates the quotient toward zero. The remainder takes the sign of the dividend.
- DIV with a = most-negative and b = -1: lo = most-negative, hi = 0, no flag.
- b=0 on DIV or DIVU: full latency still taken. Result hi=a (unmodified input), lo=all ones, div_by_zero=1 for the done cycle.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we write wdata at the edge; hi_we and lo_we together write both.
  - Ignored while busy.
  - Ignored in the cycle start is accepted (start wins).
- done and div_by_zero are never high outside the FIX→IDLE edge's following cycle.
- op, a and b are don't-care except in the start cycle.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 edges done=1, hi=0xFFFFFFFE, lo=0x00000001, busy=1 for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - Then MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0x00000000.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- DIVU a=100 b=0 -> hi=0x00000064, lo=0xFFFFFFFF, div_by_zero=1 only in the done cycle.
  - Then DIVU 100/7 -> lo=14, hi=2, div_by_zero=0.
- Preload MTHI 0xAAAA0000 and MTLO 0x5555 in IDLE.
  - Start MULTU 3×4; pulse start, hi_we and a different op mid-CALC.
  - Required: hi/lo stay 0xAAAA0000/0x5555 until done, mid-CALC start and writes ignored, final hi=0, lo=12.
- Start DIVU 1000/3, assert reset at CALC step 10.
  - Required: next cycle busy=0, hi=lo=0, no done pulse.
  - A new MULTU 6×7 then completes normally with lo=42.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine with HI/LO,
// one shift-add or restoring shift-subtract step per clock.
// Ports: clk, reset (sync, active-high); start, op, a, b request an op;
// hi_we, lo_we, wdata are MTHI/MTLO writes; busy, done, div_by_zero,
// hi, lo report status and the HI/LO registers.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             bz_q, bz_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh, div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod_mag, prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    a_d     = a_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;

    a_mag = (op[0] && a[WIDTH-1]) ? -a : a;
    b_mag = (op[0] && b[WIDTH-1]) ? -b : b;

    // acc holds the upper half of the running product; the
    // multiplier in q shifts out LSB-first as the product shifts in.
    mul_sum = {1'b0, acc_q} + {1'b0, {WIDTH{q_q[0]}} & m_q};

    // acc holds the partial remainder; dividend bits shift out of
    // q's MSB while quotient bits shift in at its LSB.
    div_sh   = {acc_q, q_q[WIDTH-1]};
    div_ok   = div_sh >= {1'b0, m_q};
    div_diff = div_sh - {1'b0, m_q};

    prod_mag = {acc_q, q_q};
    prod_res = (sa_q ^ sb_q) ? -prod_mag : prod_mag;
    quo_res  = (sa_q ^ sb_q) ? -q_q : q_q;
    rem_res  = sa_q ? -acc_q : acc_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          div_d   = op[1];
          sa_d    = op[0] & a[WIDTH-1];
          sb_d    = op[0] & b[WIDTH-1];
          bz_d    = op[1] && (b == '0);
          a_d     = a;
          acc_d   = '0;
          m_d     = op[1] ? b_mag : a_mag;
          q_d     = op[1] ? a_mag : b_mag;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      CALC: begin
        if (div_q) begin
          acc_d = div_ok ? div_diff[WIDTH-1:0]
                         : div_sh[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], div_ok};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div_q && bz_q) begin
          hi_d  = a_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else if (div_q) begin
          hi_d = rem_res;
          lo_d = quo_res;
        end else begin
          hi_d = prod_res[2*WIDTH-1:WIDTH];
          lo_d = prod_res[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      a_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      a_q     <= a_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
